decoder_and_synth: RTL and testbench
====================================

Name: decoder_and_synth

Overview:
- Receives PS/2 scan codes (KeyCode plus a break Flag) qualified by the keyboard clock KClock.
- Decodes 13 keys into a chromatic octave, C4 to C5.
- Synthesizes a square-wave tone for the board's mono audio amplifier and mirrors it to PMOD pin JA.
- Sits between the keyboard receiver and the audio output in the player-piano top level.

Parameters:
- CLK_HZ, 100_000_000: Clock frequency in Hz, used to compute tone half-periods at elaboration.
- CNT_W, 20: tone counter width. Must hold the largest half-period (191110 at 100 MHz).

Ports:
- Clock  input  1  system clock; all logic is on its rising edge.
- btnCpuReset  input  1  asynchronous, active-low reset.
- KClock  input  1  PS/2 keyboard clock, asynchronous to Clock; treated as data and synchronized.
- KeyCode  input  8  scan code (set 2), valid at the falling edge of KClock.
- Flag  input  1  break indicator, valid with KeyCode: 1 = key released, 0 = key pressed.
- JA  output  1  tone mirror to PMOD, equal to ampPWM.
- ampPWM  output  1  square-wave audio to the amplifier.
- ampSD  output  1  amplifier enable: 1 = enabled while a note plays, 0 = shutdown.

Behaviour:
- One clock domain (Clock). Reset is asynchronous and active-low (btnCpuReset = 0). While in reset every register and output is 0, and key_reg = 0x00 (no note).
- KClock passes through a 2-FF synchronizer, followed by an edge-detect flop.
- On a synchronized falling edge, key_reg <= KeyCode and brk_reg <= Flag.
- Latency: an input KClock fall is captured in key_reg by the 3rd Clock rising edge after it.
- KeyCode and Flag must be stable from 2 Clock cycles before the KClock fall until 3 Clock cycles after it.
- Decode (combinational from key_reg) gives half-period HP = round(CLK_HZ*50/F), where F is the note frequency in centi-Hz. Use 64-bit elaboration arithmetic and round half up.
- Key table, as code = key (note, F):
  - 0D = Tab (C4, 26163)
  - 16 = 1 (C#4, 27718)
  - 15 = Q (D4, 29366)
  - 1E = 2 (D#4, 31113)
  - 1D = W (E4, 32963)
  - 24 = E (F4, 34923)
  - 25 = 4 (F#4, 36999)
  - 2D = R (G4, 39200)
  - 2E = 5 (G#4, 41530)
  - 2C = T (A4, 44000)
  - 36 = 6 (A#4, 46616)
  - 35 = Y (B4, 49388)
  - 3C = U (C5, 52325)
- Any other code decodes to invalid (HP = 0).
- active = valid && !brk_reg.
- Tone generator: CNT_W-bit counter cnt and a tone flop.
  - While active: cnt increments each cycle. When cnt == HP-1, cnt <= 0 and tone toggles.
  - Output period is 2*HP cycles at 50% duty.
- While inactive: cnt = 0 and tone = 0, forced each cycle.
- Note change: when key_reg captures a code whose HP differs from the previous HP, in the same cycle cnt <= 0 and tone <= 0. The new pitch restarts with a low half-cycle.
  - Recapturing the same code does not restart the phase.
- Release then repress: a break (Flag = 1) silences output on the capture cycle +1. A later press restarts from cnt = 0.
- Outputs are registered:
  - ampPWM = tone & active.
  - JA = ampPWM.
  - ampSD = active.
  - On the cycle a note starts, ampSD rises and ampPWM is 0.
- Reset mid-tone forces all outputs to 0 immediately. After release, the block stays silent until a new KClock fall.
- KClock held constant means no capture and the current note persists indefinitely.

Test Plan:
- Reset: hold btnCpuReset = 0 for 100 ns with random KeyCode and toggling KClock -> JA = ampPWM = ampSD = 0 throughout. After release with no KClock fall, outputs stay 0.
- Press F4 (CLK_HZ = 1_000_000): KeyCode = 0x24, Flag = 0, one KClock fall -> ampSD = 1 within 4 cycles. ampPWM toggles every 1432 cycles (period 2864), and JA matches ampPWM every cycle.
- Note change: after 0x24 plays, capture 0x0D -> phase restarts low with half-period 1911. Then capture 0x2C -> half-period 1136.
- Release: capture 0x24 with Flag = 1 -> ampSD = 0 and ampPWM = 0 one cycle after capture. A following press of 0x24 with Flag = 0 restarts the tone at 1432.
- Invalid code: capture 0x1C with Flag = 0 while a note plays -> silence, ampSD = 0. Same-code recapture of 0x2C mid-tone -> no phase glitch.
- Async reset mid-tone: pull btnCpuReset low between clock edges -> outputs go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/decoder_and_synth.sv
`default_nettype none
// ============================================================================
// Module   : decoder_and_synth
// Brief    : Captures PS/2 scan codes on the keyboard clock fall, decodes 13
//            keys to a chromatic octave (C4..C5) and synthesizes a 50% duty
//            square-wave tone for the mono audio amplifier and PMOD JA.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_and_synth #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned CNT_W  = 20
) (
   input  logic       Clock,
   input  logic       btnCpuReset,
   input  logic       KClock,
   input  logic [7:0] KeyCode,
   input  logic       Flag,
   output logic       JA,
   output logic       ampPWM,
   output logic       ampSD
);

   // Half-period in Clock cycles for a note given in centi-Hz, rounded half up.
   function automatic logic [CNT_W-1:0] calcHp(input logic [63:0] fCenti);
      logic [63:0] num;
      num = 64'(CLK_HZ) * 64'd100 + fCenti;
      return CNT_W'(num / (64'd2 * fCenti));
   endfunction

   localparam logic [CNT_W-1:0] c_HP_C4  = calcHp(64'd26163);
   localparam logic [CNT_W-1:0] c_HP_CS4 = calcHp(64'd27718);
   localparam logic [CNT_W-1:0] c_HP_D4  = calcHp(64'd29366);
   localparam logic [CNT_W-1:0] c_HP_DS4 = calcHp(64'd31113);
   localparam logic [CNT_W-1:0] c_HP_E4  = calcHp(64'd32963);
   localparam logic [CNT_W-1:0] c_HP_F4  = calcHp(64'd34923);
   localparam logic [CNT_W-1:0] c_HP_FS4 = calcHp(64'd36999);
   localparam logic [CNT_W-1:0] c_HP_G4  = calcHp(64'd39200);
   localparam logic [CNT_W-1:0] c_HP_GS4 = calcHp(64'd41530);
   localparam logic [CNT_W-1:0] c_HP_A4  = calcHp(64'd44000);
   localparam logic [CNT_W-1:0] c_HP_AS4 = calcHp(64'd46616);
   localparam logic [CNT_W-1:0] c_HP_B4  = calcHp(64'd49388);
   localparam logic [CNT_W-1:0] c_HP_C5  = calcHp(64'd52325);

   // Scan code (set 2) to half-period; zero marks a key outside the octave.
   function automatic logic [CNT_W-1:0] decodeHp(input logic [7:0] code);
      case (code)
         8'h0D:   return c_HP_C4;
         8'h16:   return c_HP_CS4;
         8'h15:   return c_HP_D4;
         8'h1E:   return c_HP_DS4;
         8'h1D:   return c_HP_E4;
         8'h24:   return c_HP_F4;
         8'h25:   return c_HP_FS4;
         8'h2D:   return c_HP_G4;
         8'h2E:   return c_HP_GS4;
         8'h2C:   return c_HP_A4;
         8'h36:   return c_HP_AS4;
         8'h35:   return c_HP_B4;
         8'h3C:   return c_HP_C5;
         default: return '0;
      endcase
   endfunction

   logic             r_kSync1;
   logic             r_kSync2;
   logic             r_kPrev;
   logic [7:0]       r_keyReg;
   logic             r_brkReg;
   logic [CNT_W-1:0] r_cnt;
   logic             r_tone;

   logic             w_kFall;
   logic [CNT_W-1:0] w_hp;
   logic [CNT_W-1:0] w_newHp;
   logic             w_active;
   logic             w_pitchChange;

   assign w_kFall       = r_kPrev & ~r_kSync2;
   assign w_hp          = decodeHp(r_keyReg);
   assign w_newHp       = decodeHp(KeyCode);
   assign w_active      = (w_hp != '0) & ~r_brkReg;
   // A capture that changes pitch restarts the phase on the capture edge itself.
   assign w_pitchChange = w_kFall & (w_newHp != w_hp);

   // Bring the keyboard clock into the Clock domain and keep a delayed copy for edge detection.
   always_ff @(posedge Clock or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         r_kSync1 <= 1'b0;
         r_kSync2 <= 1'b0;
         r_kPrev  <= 1'b0;
      end else begin
         r_kSync1 <= KClock;
         r_kSync2 <= r_kSync1;
         r_kPrev  <= r_kSync2;
      end
   end

   // Latch scan code and break flag on each synchronized keyboard clock fall.
   always_ff @(posedge Clock or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         r_keyReg <= 8'h00;
         r_brkReg <= 1'b0;
      end else if (w_kFall) begin
         r_keyReg <= KeyCode;
         r_brkReg <= Flag;
      end
   end

   // Half-period counter and tone flop; held at zero while silent or on a pitch change.
   always_ff @(posedge Clock or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         r_cnt  <= '0;
         r_tone <= 1'b0;
      end else if (!w_active || w_pitchChange) begin
         r_cnt  <= '0;
         r_tone <= 1'b0;
      end else if (r_cnt == w_hp - CNT_W'(1)) begin
         r_cnt  <= '0;
         r_tone <= ~r_tone;
      end else begin
         r_cnt  <= r_cnt + CNT_W'(1);
      end
   end

   // Registered amplifier drive and enable.
   always_ff @(posedge Clock or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         ampPWM <= 1'b0;
         ampSD  <= 1'b0;
      end else begin
         ampPWM <= r_tone & w_active;
         ampSD  <= w_active;
      end
   end

   assign JA = ampPWM;

endmodule
`default_nettype wire

// File: tb/tb_decoder_and_synth.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_and_synth
// Brief    : Self-checking bench for decoder_and_synth. A note-level model
//            (pitch, phase origin, silence) predicts outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_and_synth;

   localparam int unsigned CLK_HZ = 1_000_000;
   localparam int unsigned CNT_W  = 20;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b1;
   logic       KClock  = 1'b1;
   logic [7:0] KeyCode = 8'h00;
   logic       Flag    = 1'b0;
   logic       JA;
   logic       ampPWM;
   logic       ampSD;

   decoder_and_synth #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
      .Clock      (clk),
      .btnCpuReset(rst_n),
      .KClock     (KClock),
      .KeyCode    (KeyCode),
      .Flag       (Flag),
      .JA         (JA),
      .ampPWM     (ampPWM),
      .ampSD      (ampSD)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   task automatic cmp(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   // ---------------- note table and reference model ----------------
   logic [7:0] keyCodes [13] = '{8'h0D, 8'h16, 8'h15, 8'h1E, 8'h1D, 8'h24, 8'h25,
                                 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3C};
   int         keyF     [13] = '{26163, 27718, 29366, 31113, 32963, 34923, 36999,
                                 39200, 41530, 44000, 46616, 49388, 52325};

   function automatic int hpOf(input logic [7:0] code);
      for (int i = 0; i < 13; i++)
         if (keyCodes[i] == code)
            return int'((longint'(CLK_HZ) * 100 + longint'(keyF[i])) / (2 * longint'(keyF[i])));
      return 0;
   endfunction

   typedef struct {
      int         due;
      logic [7:0] code;
      logic       flag;
   } cap_t;

   cap_t pend[$];
   int   cyc    = 0;
   int   mHp    = 0;
   bit   mBrk   = 0;
   int   mT0    = 0;
   bit   expSD  = 0;
   bit   expPWM = 0;

   // Model: a note sounds while its pitch is valid and not released; the
   // square wave is low for HP cycles from its phase origin, then high for HP.
   always @(posedge clk) begin
      bit   act;
      int   nh;
      cap_t c;
      cyc++;
      if (!rst_n) begin
         mHp = 0; mBrk = 0; mT0 = 0;
         expSD = 0; expPWM = 0;
         pend.delete();
      end else begin
         act    = (mHp != 0) && !mBrk;
         expSD  = act;
         expPWM = 0;
         if (act) expPWM = (((cyc - 1 - mT0) / mHp) % 2) == 1;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            c  = pend.pop_front();
            nh = hpOf(c.code);
            if (nh != mHp || !act) mT0 = cyc;
            mHp  = nh;
            mBrk = c.flag;
         end
      end
   end

   // Per-cycle comparison, sampled mid-cycle.
   always @(negedge clk) begin
      cmp("ampSD",  int'(ampSD),  rst_n ? int'(expSD)  : 0);
      cmp("ampPWM", int'(ampPWM), rst_n ? int'(expPWM) : 0);
      cmp("JA",     int'(JA),     rst_n ? int'(expPWM) : 0);
   end

   // ---------------- stimulus helpers ----------------
   task automatic keyEvent(input logic [7:0] code, input logic flag);
      cap_t c;
      @(negedge clk);
      KeyCode = code;
      Flag    = flag;
      repeat (2) @(negedge clk);
      KClock = 1'b0;
      c.due = cyc + 3; c.code = code; c.flag = flag;
      pend.push_back(c);
      repeat (4) @(negedge clk);
      KClock  = 1'b1;
      KeyCode = 8'($urandom);
      Flag    = 1'($urandom);
   endtask

   // Measure one high half-cycle of ampPWM in Clock cycles.
   task automatic measureHalf(input string name, input int hp);
      logic prev;
      int   t;
      int   n;
      @(negedge clk);
      prev = ampPWM;
      for (t = 0; t < 4 * hp; t++) begin
         @(negedge clk);
         if (!prev && ampPWM) break;
         prev = ampPWM;
      end
      if (t >= 4 * hp) begin
         cmp({name, " rise timeout"}, 0, 1);
         return;
      end
      n = 0;
      while (ampPWM && n < 4 * hp) begin
         @(negedge clk);
         n++;
      end
      cmp(name, n, hp);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      // Model pinning against hand-computed half-periods at 1 MHz.
      cmp("hp F4", hpOf(8'h24), 1432);
      cmp("hp C4", hpOf(8'h0D), 1911);
      cmp("hp A4", hpOf(8'h2C), 1136);
      cmp("hp C5", hpOf(8'h3C), 956);
      cmp("hp bad", hpOf(8'h1C), 0);

      // Reset with random codes and a toggling keyboard clock.
      #1 rst_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         KeyCode = 8'($urandom);
         Flag    = 1'($urandom);
         KClock  = ~KClock;
      end
      @(negedge clk);
      KClock = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Press F4, then note changes.
      keyEvent(8'h24, 1'b0);
      measureHalf("half F4", 1432);
      repeat (1500) @(negedge clk);
      keyEvent(8'h0D, 1'b0);
      measureHalf("half C4", 1911);
      keyEvent(8'h2C, 1'b0);
      measureHalf("half A4", 1136);
      repeat (700) @(negedge clk);
      keyEvent(8'h2C, 1'b0);
      repeat (2500) @(negedge clk);

      // Invalid key while playing.
      keyEvent(8'h1C, 1'b0);
      repeat (50) @(negedge clk);

      // Press, release, repress.
      keyEvent(8'h24, 1'b0);
      repeat (2000) @(negedge clk);
      keyEvent(8'h24, 1'b1);
      repeat (50) @(negedge clk);
      keyEvent(8'h24, 1'b0);
      measureHalf("half F4 repress", 1432);

      // Asynchronous reset between clock edges while high.
      while (!ampPWM) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      cmp("async ampSD",  int'(ampSD),  0);
      cmp("async ampPWM", int'(ampPWM), 0);
      cmp("async JA",     int'(JA),     0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);

      // Randomized key traffic.
      for (int i = 0; i < 12; i++) begin
         logic [7:0] code;
         code = ($urandom_range(0, 4) == 0) ? 8'($urandom) : keyCodes[$urandom_range(0, 12)];
         keyEvent(code, ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(10, 1500)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
